sctag_err_log_ctl: RTL and testbench
====================================

# sctag_err_log_ctl

Error logging and notification stage directly downstream of the L2 data ECC control. It consumes the C8 classified error strobes (SPARC, BIST/scan, scrub and fill-buffer, correctable and uncorrectable), the C8 address and thread ID. It logs the first error of each severity into an error status register (ESR) and error address register (EAR), records multiple-error overflow, and counts correctable errors. It raises a held request/acknowledge notification toward the CPX error-return path.

## Interface
- No parameters.
- rclk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- decc_spcd_corr_err_c8 / decc_spcd_uncorr_err_c8  in  1 each  SPARC data read error.
- decc_bscd_corr_err_c8 / decc_bscd_uncorr_err_c8  in  1 each  BIST/scan data read error.
- decc_scrd_corr_err_c8 / decc_scrd_uncorr_err_c8  in  1 each  scrub read error.
- decc_spcfb_corr_err_c8 / decc_spcfb_uncorr_err_c8  in  1 each  fill-buffer read error.
- err_addr_c8  in  36  physical address [39:4] of the C8 access.
- err_thrid_c8  in  5  requesting thread ID.
- error_ceen, error_nceen  in  1 each  notification enables; used directly, not re-flopped here.
- csr_esr_wr  in  1  write-one-to-clear strobe for the ESR.
- csr_wr_data  in  16  clear mask, aligned to the err_status bits.
- csr_cec_clr  in  1  clears the correctable error counter.
- err_ack  in  1  acknowledge for err_req.
- err_status  out  16  ESR contents:
  - [15] MEU, [14] MEC
  - [13] LDAU, [12] LDAC (SPARC)
  - [11] LDRU, [10] LDRC (BIST/scan)
  - [9] LDSU, [8] LDSC (scrub)
  - [7] LDFU, [6] LDFC (fill buffer)
  - [5] 0
  - [4:0] thread ID
- err_addr  out  36  EAR.
- err_cec  out  4  saturating correctable error count.
- err_req  out  1  notification request.
- err_req_uncorr  out  1  request type: 1 = uncorrectable; valid while err_req is high.

## Operation
- Per cycle, compute:
  - U = OR of the enabled uncorr strobes.
  - C = OR of the enabled corr strobes.
- Clear first: csr_esr_wr clears every ESR bit whose csr_wr_data bit is 1. Logging is then evaluated on the cleared value.
- ESR state:
  - "U-logged" = any of LDxU set.
  - "empty" = all LDx bits clear.
- On U:
  - If not U-logged: set the matching LDxU bits, load EAR and thread ID.
  - If U-logged: set MEU; EAR and thread ID unchanged.
- On C:
  - If empty and U is not also present this cycle: set the matching LDxC bits, load EAR and thread ID.
  - If empty and U is present this cycle: set the matching LDxC bits; EAR and thread ID come from the uncorrectable log (same address).
  - If not empty: set MEC; LDxC bits unchanged.
- An uncorrectable error over a correctable-only log keeps the LDxC bits and overwrites EAR and thread ID. MEC is unchanged.
- CEC increments by 1 on every cycle with C, saturating at 15. csr_cec_clr zeroes it. If the clear and C occur in the same cycle, the result is 1.
- Notification uses two pending flags, pend_u and pend_c:
  - U & error_nceen sets pend_u; C & error_ceen sets pend_c.
  - FSM IDLE → REQ when either flag is set. Uncorrectable is selected first.
  - In REQ, err_req = 1 and err_req_uncorr is held stable.
  - err_ack in REQ clears the served flag and moves to IDLE; err_req drops the next cycle.
  - New events during REQ only set flags. A second event of the same type while its flag is set is absorbed.
  - err_ack outside REQ is ignored.

## Timing
- Reset values: err_status 0, err_addr 0, err_cec 0, err_req 0, err_req_uncorr 0. Pending flags clear, FSM in IDLE.
- C8 strobes are registered into ESR/EAR/CEC; the update is visible in C9 (1-cycle latency).
- err_req rises in C9 for an event in C8, from IDLE.
- Ack in cycle N: err_req low in N+1. A remaining pending flag re-raises err_req in N+2.
- Reset asserted mid-request drops err_req the next cycle and discards pending flags.

## Configuration
- SCTAG_ERR_SCRUB_LOG_EN defined: the scrub strobes participate in U, C, CEC, MEU/MEC and notification, and set LDSU/LDSC.
- SCTAG_ERR_SCRUB_LOG_EN undefined: the scrub strobes are ignored entirely, and LDSU/LDSC read 0.

## Test plan
- Single corr: decc_spcd_corr_err_c8 = 1, addr 0x123456789, thr 5, ceen = 1 → next cycle err_status = 0x1005, err_addr = 0x123456789, err_cec = 1, err_req = 1, err_req_uncorr = 0.
- Overflow: two uncorr events (fill-buffer, then SPARC) → LDFU = 1, MEU = 1, LDAU = 0, EAR holds the first address.
- Priority: corr and uncorr pending together, nceen = ceen = 1 → uncorr request first; ack → err_req low one cycle, then high with err_req_uncorr = 0.
- W1C race: csr_esr_wr with mask 0xFFFF in the same cycle as a scrub corr (macro on) → err_status = LDSC plus the new thread ID, MEC = 0.
- CEC saturation: 20 corr events → err_cec = 15; csr_cec_clr together with a corr event → err_cec = 1.
- Macro off: scrub uncorr strobe alone → err_status stays 0, err_req stays 0.

Source files
------------

// File: rtl/sctag_err_log_ctl_if.sv
// Bus bundle between the L2 data ECC control, the CSR block and the error
// logging stage: C8 error strobes, access address/thread, CSR controls and
// the held error notification handshake.
interface sctag_err_log_ctl_if;
    logic        decc_spcd_corr_err_c8;
    logic        decc_spcd_uncorr_err_c8;
    logic        decc_bscd_corr_err_c8;
    logic        decc_bscd_uncorr_err_c8;
    logic        decc_scrd_corr_err_c8;
    logic        decc_scrd_uncorr_err_c8;
    logic        decc_spcfb_corr_err_c8;
    logic        decc_spcfb_uncorr_err_c8;
    logic [35:0] err_addr_c8;
    logic [4:0]  err_thrid_c8;
    logic        error_ceen;
    logic        error_nceen;
    logic        csr_esr_wr;
    logic [15:0] csr_wr_data;
    logic        csr_cec_clr;
    logic        err_ack;
    logic [15:0] err_status;
    logic [35:0] err_addr;
    logic [3:0]  err_cec;
    logic        err_req;
    logic        err_req_uncorr;

    modport master (
        output decc_spcd_corr_err_c8, decc_spcd_uncorr_err_c8,
        output decc_bscd_corr_err_c8, decc_bscd_uncorr_err_c8,
        output decc_scrd_corr_err_c8, decc_scrd_uncorr_err_c8,
        output decc_spcfb_corr_err_c8, decc_spcfb_uncorr_err_c8,
        output err_addr_c8, err_thrid_c8, error_ceen, error_nceen,
        output csr_esr_wr, csr_wr_data, csr_cec_clr, err_ack,
        input  err_status, err_addr, err_cec, err_req, err_req_uncorr
    );

    modport slave (
        input  decc_spcd_corr_err_c8, decc_spcd_uncorr_err_c8,
        input  decc_bscd_corr_err_c8, decc_bscd_uncorr_err_c8,
        input  decc_scrd_corr_err_c8, decc_scrd_uncorr_err_c8,
        input  decc_spcfb_corr_err_c8, decc_spcfb_uncorr_err_c8,
        input  err_addr_c8, err_thrid_c8, error_ceen, error_nceen,
        input  csr_esr_wr, csr_wr_data, csr_cec_clr, err_ack,
        output err_status, err_addr, err_cec, err_req, err_req_uncorr
    );
endinterface

// File: rtl/sctag_err_log_ctl.sv
// L2 error logging stage: first-error ESR/EAR capture, multiple-error
// overflow, saturating correctable error counter and a held req/ack
// notification toward the CPX error-return path.
// Optional macro SCTAG_ERR_SCRUB_LOG_EN: when defined, scrub read errors
// are logged and notified; otherwise the scrub strobes are ignored.
//
// state    | meaning
// ST_IDLE  | no request outstanding; launches one as soon as a flag is pending
// ST_REQ   | err_req held high with a stable type until err_ack
module sctag_err_log_ctl (
    input  logic rclk,
    input  logic reset,
    sctag_err_log_ctl_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t      state;
    logic [15:0] esr_q;
    logic [35:0] ear_q;
    logic [3:0]  cec_q;
    logic        req_q;
    logic        req_uncorr_q;
    logic        pend_u;
    logic        pend_c;

    logic        scrd_corr;
    logic        scrd_uncorr;
    logic        evt_u;
    logic        evt_c;
    logic        new_u;
    logic        new_c;
    logic        served_u;
    logic        served_c;
    logic [15:0] esr_clr;
    logic [15:0] esr_nxt;
    logic [35:0] ear_nxt;
    logic [3:0]  cec_nxt;
    logic        u_logged;
    logic        log_empty;

`ifdef SCTAG_ERR_SCRUB_LOG_EN
    assign scrd_corr   = bus.decc_scrd_corr_err_c8;
    assign scrd_uncorr = bus.decc_scrd_uncorr_err_c8;
`else
    logic unused_scrub;
    assign unused_scrub = bus.decc_scrd_corr_err_c8 | bus.decc_scrd_uncorr_err_c8;
    assign scrd_corr    = 1'b0;
    assign scrd_uncorr  = 1'b0;
`endif

    assign evt_u = bus.decc_spcd_uncorr_err_c8 | bus.decc_bscd_uncorr_err_c8 |
                   scrd_uncorr | bus.decc_spcfb_uncorr_err_c8;
    assign evt_c = bus.decc_spcd_corr_err_c8 | bus.decc_bscd_corr_err_c8 |
                   scrd_corr | bus.decc_spcfb_corr_err_c8;

    assign new_u    = evt_u & bus.error_nceen;
    assign new_c    = evt_c & bus.error_ceen;
    assign served_u = (state == ST_REQ) & bus.err_ack & req_uncorr_q;
    assign served_c = (state == ST_REQ) & bus.err_ack & ~req_uncorr_q;

    // Next ESR/EAR: apply the W1C clear, then log against the cleared value
    always_comb begin
        esr_clr   = bus.csr_esr_wr ? (esr_q & ~bus.csr_wr_data) : esr_q;
        u_logged  = esr_clr[13] | esr_clr[11] | esr_clr[9] | esr_clr[7];
        log_empty = (esr_clr[13:6] == 8'h00);
        esr_nxt   = esr_clr;
        ear_nxt   = ear_q;
        if (evt_u) begin
            if (!u_logged) begin
                esr_nxt[13]  = esr_clr[13] | bus.decc_spcd_uncorr_err_c8;
                esr_nxt[11]  = esr_clr[11] | bus.decc_bscd_uncorr_err_c8;
                esr_nxt[9]   = esr_clr[9]  | scrd_uncorr;
                esr_nxt[7]   = esr_clr[7]  | bus.decc_spcfb_uncorr_err_c8;
                esr_nxt[4:0] = bus.err_thrid_c8;
                ear_nxt      = bus.err_addr_c8;
            end else begin
                esr_nxt[15] = 1'b1;
            end
        end
        if (evt_c) begin
            if (log_empty) begin
                esr_nxt[12] = bus.decc_spcd_corr_err_c8;
                esr_nxt[10] = bus.decc_bscd_corr_err_c8;
                esr_nxt[8]  = scrd_corr;
                esr_nxt[6]  = bus.decc_spcfb_corr_err_c8;
                // With a simultaneous uncorrectable the address was already
                // taken from the same access above.
                if (!evt_u) begin
                    esr_nxt[4:0] = bus.err_thrid_c8;
                    ear_nxt      = bus.err_addr_c8;
                end
            end else begin
                esr_nxt[14] = 1'b1;
            end
        end
        esr_nxt[5] = 1'b0;
    end

    // Next CEC: clear wins over history but still counts a same-cycle event
    always_comb begin
        cec_nxt = cec_q;
        if (bus.csr_cec_clr) begin
            cec_nxt = evt_c ? 4'd1 : 4'd0;
        end else if (evt_c && (cec_q != 4'hF)) begin
            cec_nxt = cec_q + 4'd1;
        end
    end

    // Log registers
    always_ff @(posedge rclk) begin
        if (reset) begin
            esr_q <= '0;
            ear_q <= '0;
            cec_q <= '0;
        end else begin
            esr_q <= esr_nxt;
            ear_q <= ear_nxt;
            cec_q <= cec_nxt;
        end
    end

    // Notification FSM with pending flags; uncorrectable served first
    always_ff @(posedge rclk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_q        <= 1'b0;
            req_uncorr_q <= 1'b0;
            pend_u       <= 1'b0;
            pend_c       <= 1'b0;
        end else begin
            pend_u <= (pend_u & ~served_u) | new_u;
            pend_c <= (pend_c & ~served_c) | new_c;
            case (state)
                ST_IDLE: begin
                    // Include this cycle's events so the request rises in C9
                    if (pend_u | pend_c | new_u | new_c) begin
                        state        <= ST_REQ;
                        req_q        <= 1'b1;
                        req_uncorr_q <= pend_u | new_u;
                    end
                end
                ST_REQ: begin
                    if (bus.err_ack) begin
                        state        <= ST_IDLE;
                        req_q        <= 1'b0;
                        req_uncorr_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    req_q        <= 1'b0;
                    req_uncorr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.err_status     = esr_q;
    assign bus.err_addr       = ear_q;
    assign bus.err_cec        = cec_q;
    assign bus.err_req        = req_q;
    assign bus.err_req_uncorr = req_uncorr_q;
endmodule

// File: tb/tb_sctag_err_log_ctl.sv
// Directed self-checking bench for sctag_err_log_ctl. Inputs change on the
// falling edge; outputs are checked on the falling edge after each rising edge.
module tb_sctag_err_log_ctl;
    logic rclk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_mis = 0;

    sctag_err_log_ctl_if bus ();

    sctag_err_log_ctl dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_strobes();
        bus.decc_spcd_corr_err_c8    = 1'b0;
        bus.decc_spcd_uncorr_err_c8  = 1'b0;
        bus.decc_bscd_corr_err_c8    = 1'b0;
        bus.decc_bscd_uncorr_err_c8  = 1'b0;
        bus.decc_scrd_corr_err_c8    = 1'b0;
        bus.decc_scrd_uncorr_err_c8  = 1'b0;
        bus.decc_spcfb_corr_err_c8   = 1'b0;
        bus.decc_spcfb_uncorr_err_c8 = 1'b0;
        bus.csr_esr_wr               = 1'b0;
        bus.csr_wr_data              = 16'h0000;
        bus.csr_cec_clr              = 1'b0;
        bus.err_ack                  = 1'b0;
    endtask

    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic clear_log();
        bus.csr_esr_wr  = 1'b1;
        bus.csr_wr_data = 16'hFFFF;
        bus.csr_cec_clr = 1'b1;
        step();
        clr_strobes();
    endtask

    task automatic set_access(input logic [35:0] a, input logic [4:0] t);
        bus.err_addr_c8  = a;
        bus.err_thrid_c8 = t;
    endtask

    initial begin
        clr_strobes();
        set_access(36'h0, 5'd0);
        bus.error_ceen  = 1'b0;
        bus.error_nceen = 1'b0;
        reset = 1'b1;
        @(negedge rclk);
        repeat (3) step();
        check_val("rst_status", bus.err_status, 36'h0);
        check_val("rst_addr", bus.err_addr, 36'h0);
        check_val("rst_cec", bus.err_cec, 36'h0);
        check_val("rst_req", bus.err_req, 36'h0);
        check_val("rst_req_uncorr", bus.err_req_uncorr, 36'h0);
        reset = 1'b0;

        // Single correctable
        bus.error_ceen  = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_spcd_corr_err_c8 = 1'b1;
        set_access(36'h123456789, 5'd5);
        step();
        clr_strobes();
        check_val("single_status", bus.err_status, 36'h1005);
        check_val("single_addr", bus.err_addr, 36'h123456789);
        check_val("single_cec", bus.err_cec, 36'd1);
        check_val("single_req", bus.err_req, 36'd1);
        check_val("single_req_uncorr", bus.err_req_uncorr, 36'd0);
        bus.err_ack = 1'b1;
        step();
        clr_strobes();
        check_val("single_ack_drop", bus.err_req, 36'd0);
        step();
        check_val("single_no_rereq", bus.err_req, 36'd0);
        clear_log();
        check_val("w1c_status", bus.err_status, 36'h0);
        check_val("cec_clr", bus.err_cec, 36'h0);

        // Uncorrectable overflow: fill buffer then SPARC
        bus.error_ceen = 1'b0;
        bus.decc_spcfb_uncorr_err_c8 = 1'b1;
        set_access(36'hA00000010, 5'd3);
        step();
        clr_strobes();
        check_val("ovf_req", bus.err_req, 36'd1);
        check_val("ovf_req_uncorr", bus.err_req_uncorr, 36'd1);
        bus.decc_spcd_uncorr_err_c8 = 1'b1;
        set_access(36'h00BAD0000, 5'd7);
        step();
        clr_strobes();
        check_val("ovf_status", bus.err_status, 36'h8083);
        check_val("ovf_addr", bus.err_addr, 36'hA00000010);
        bus.err_ack = 1'b1;
        step();
        clr_strobes();
        check_val("ovf_ack_drop", bus.err_req, 36'd0);
        step();
        check_val("ovf_absorbed", bus.err_req, 36'd0);
        clear_log();

        // Priority: corr and uncorr in the same cycle
        bus.error_ceen  = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_spcd_corr_err_c8   = 1'b1;
        bus.decc_bscd_uncorr_err_c8 = 1'b1;
        set_access(36'h555555550, 5'd9);
        step();
        clr_strobes();
        check_val("prio_status", bus.err_status, 36'h1809);
        check_val("prio_addr", bus.err_addr, 36'h555555550);
        check_val("prio_cec", bus.err_cec, 36'd1);
        check_val("prio_req", bus.err_req, 36'd1);
        check_val("prio_first_uncorr", bus.err_req_uncorr, 36'd1);
        bus.err_ack = 1'b1;
        step();
        clr_strobes();
        check_val("prio_gap", bus.err_req, 36'd0);
        step();
        check_val("prio_rereq", bus.err_req, 36'd1);
        check_val("prio_second_corr", bus.err_req_uncorr, 36'd0);
        bus.err_ack = 1'b1;
        step();
        clr_strobes();
        check_val("prio_done", bus.err_req, 36'd0);
        clear_log();
        bus.err_ack = 1'b1;
        step();
        clr_strobes();
        check_val("stray_ack", bus.err_req, 36'd0);

        // Uncorr over a correctable-only log, then MEC
        bus.error_ceen  = 1'b0;
        bus.error_nceen = 1'b0;
        bus.decc_spcfb_corr_err_c8 = 1'b1;
        set_access(36'h000000AA0, 5'd2);
        step();
        clr_strobes();
        check_val("conly_status", bus.err_status, 36'h0042);
        bus.decc_spcd_uncorr_err_c8 = 1'b1;
        set_access(36'hF00000001, 5'd4);
        step();
        clr_strobes();
        check_val("u_over_c_status", bus.err_status, 36'h2044);
        check_val("u_over_c_addr", bus.err_addr, 36'hF00000001);
        bus.decc_spcd_corr_err_c8 = 1'b1;
        set_access(36'h000000001, 5'd1);
        step();
        clr_strobes();
        check_val("mec_status", bus.err_status, 36'h6044);
        check_val("mec_addr", bus.err_addr, 36'hF00000001);
        check_val("mec_cec", bus.err_cec, 36'd2);
        check_val("mec_no_req", bus.err_req, 36'd0);

        // CEC saturation and clear racing an event
        bus.csr_cec_clr = 1'b1;
        step();
        clr_strobes();
        check_val("cec_zero", bus.err_cec, 36'd0);
        bus.decc_bscd_corr_err_c8 = 1'b1;
        repeat (20) step();
        clr_strobes();
        check_val("cec_sat", bus.err_cec, 36'd15);
        bus.decc_bscd_corr_err_c8 = 1'b1;
        bus.csr_cec_clr = 1'b1;
        step();
        clr_strobes();
        check_val("cec_clr_race", bus.err_cec, 36'd1);

`ifdef SCTAG_ERR_SCRUB_LOG_EN
        // W1C of a full log racing a scrub correctable
        bus.csr_esr_wr  = 1'b1;
        bus.csr_wr_data = 16'hFFFF;
        bus.decc_scrd_corr_err_c8 = 1'b1;
        set_access(36'h300003000, 5'd31);
        step();
        clr_strobes();
        check_val("w1c_race_status", bus.err_status, 36'h011F);
        check_val("w1c_race_addr", bus.err_addr, 36'h300003000);
        check_val("w1c_race_cec", bus.err_cec, 36'd2);
`else
        // Scrub strobes must be invisible
        bus.csr_esr_wr  = 1'b1;
        bus.csr_wr_data = 16'hFFFF;
        step();
        clr_strobes();
        bus.error_ceen  = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_scrd_uncorr_err_c8 = 1'b1;
        bus.decc_scrd_corr_err_c8   = 1'b1;
        set_access(36'h300003000, 5'd6);
        step();
        clr_strobes();
        check_val("scrub_off_status", bus.err_status, 36'h0);
        check_val("scrub_off_req", bus.err_req, 36'd0);
        check_val("scrub_off_cec", bus.err_cec, 36'd1);
        step();
        check_val("scrub_off_req_late", bus.err_req, 36'd0);
`endif

        // Reset in the middle of a request discards pending work
        bus.error_ceen  = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_spcd_uncorr_err_c8 = 1'b1;
        bus.decc_bscd_corr_err_c8   = 1'b1;
        set_access(36'h0000FFFF0, 5'd12);
        step();
        clr_strobes();
        check_val("mid_req", bus.err_req, 36'd1);
        reset = 1'b1;
        step();
        check_val("mid_rst_req", bus.err_req, 36'd0);
        check_val("mid_rst_status", bus.err_status, 36'h0);
        reset = 1'b0;
        step();
        check_val("post_rst_req1", bus.err_req, 36'd0);
        step();
        check_val("post_rst_req2", bus.err_req, 36'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
